rice_decoder: RTL and testbench
===============================

Name: rice_decoder

Overview:
- Bit-serial Rice codeword decoder for one residual partition of a FLAC subframe.
- Consumes the residual bitstream one bit per handshake and splits each codeword into a unary quotient (MSB) and a k-bit remainder (LSB).
- Presents each (MSB, LSB) pair on a valid/ready output to the downstream residual demapper, one pair per coded sample, until the partition's sample count is exhausted.

Parameters:
- MSB_W, 16, width of unary quotient counter and oMSB
- LSB_W, 16, width of remainder shift register and oLSB
- PARAM_W, 4, width of Rice parameter
- CNT_W, 16, width of partition sample counter

Ports:
- iClk  in  1  clock
- iRst_n  in  1  asynchronous active-low reset
- iPartStart  in  1  one-cycle pulse; latches iRiceParam and iPartSamples, starts partition
- iRiceParam  in  PARAM_W  Rice parameter k for the partition
- iPartSamples  in  CNT_W  number of residuals in the partition (0 = empty partition)
- iBit  in  1  next bitstream bit, MSB-first order
- iBitValid  in  1  iBit is valid
- oBitReady  out  1  decoder accepts iBit this cycle
- oMSB  out  MSB_W  unary quotient (count of 0s before terminating 1)
- oLSB  out  LSB_W  k-bit remainder, right-aligned, upper bits zero
- oValid  out  1  oMSB/oLSB hold a decoded pair
- iReady  in  1  downstream accepts pair
- oPartDone  out  1  one-cycle pulse after the last pair of the partition is accepted
- oBusy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters and registers 0. Reset mid-partition abandons the partition; no pair or oPartDone is emitted.
- Bit transfer: a bit is consumed iff iBitValid && oBitReady. oBitReady = 1 only in UNARY and BINARY.
- Output transfer: a pair is consumed iff oValid && iReady. oMSB/oLSB stay stable while oValid=1 and iReady=0.
- States:
  - IDLE: on iPartStart, latch k and remaining count.
    - If count=0, go to DONE.
    - Otherwise clear the quotient and go to UNARY.
    - iPartStart is ignored outside IDLE.
  - UNARY: consumed 0 increments the quotient. Consumed 1 goes to BINARY if k!=0; if k=0, it goes to OUT with LSB=0.
  - BINARY: consumed bits shift into the remainder (new bit at LSB). The bit counter counts k bits; after the k-th bit, go to OUT.
  - OUT: oValid=1, registered, asserted the cycle after the terminating bit is consumed. On handshake, decrement remaining.
    - If remaining becomes 0, go to DONE.
    - Otherwise clear the quotient/remainder and go to UNARY.
    - No bit is accepted in OUT.
  - DONE: oPartDone=1 for exactly one cycle, then IDLE.
- Latency: terminating bit (k=0) or last remainder bit consumed at cycle N; oValid high at N+1.
- Throughput: one codeword every q+1+k+1 cycles with iReady held high.
- Widths:
  - k up to 2^PARAM_W-1 with LSB_W >= that; k=15 is treated as a plain parameter, with no escape handling here.
  - Quotient wraps modulo 2^MSB_W unless the optional feature is enabled.
- iBitValid low stalls in the current state without a state change.

Optional Feature:
- Macro: RICE_OVF_DET_EN.
- Enabled:
  - Adds output port oErr (1 bit).
  - In UNARY, a consumed 0 while the quotient is all-ones sets oErr sticky, jumps to IDLE and drops the partition.
  - oErr clears only on reset or the next iPartStart.
- Disabled: no oErr port; the quotient wraps silently.

Decomposition:
- Shared package rice_pkg holds:
  - state enum (IDLE, UNARY, BINARY, OUT, DONE)
  - width constants MSB_W, LSB_W, PARAM_W, CNT_W (also used by the demapper and partition parser)
  - RICE_PARAM_ESCAPE = 4'hF constant, for the parser
- Natural sub-module: rice_bit_shifter, holding the remainder shift register plus the k-bit counter with a done flag.
- FSM, quotient counter and sample counter stay in the top module.

Test Plan:
- k=2, samples=1, bits 0,0,0,1,1,0 with iReady=1 -> oValid one cycle after the 6th bit; oMSB=3, oLSB=2; oPartDone pulses the cycle after the handshake.
- k=0, samples=3, bits 1, 01, 001 -> pairs (0,0), (1,0), (2,0); oBitReady low during each OUT cycle.
- k=4, samples=2, iReady held low 5 cycles on the first pair -> oMSB/oLSB stable, no bits consumed; then second pair decodes correctly.
- samples=0 with iPartStart -> oPartDone the cycle after IDLE; no oValid; oBitReady never high.
- Assert iRst_n low during BINARY of a k=3 codeword -> all outputs 0 immediately; after release a fresh partition decodes normally.
- RICE_OVF_DET_EN with MSB_W=4, 16 consecutive 0 bits -> oErr=1, state IDLE, no oValid.

Source files
------------

// File: rtl/rice_pkg.sv
// Shared types and widths for the FLAC Rice residual path (decoder, demapper, partition parser).
package rice_pkg;

    localparam int MSB_W   = 16;
    localparam int LSB_W   = 16;
    localparam int PARAM_W = 4;
    localparam int CNT_W   = 16;

    // Parameter value that flags an escaped (verbatim) partition; handled by the parser.
    localparam logic [PARAM_W-1:0] RICE_PARAM_ESCAPE = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        UNARY,
        BINARY,
        OUT,
        DONE
    } state_t;

endpackage

// File: rtl/rice_if.sv
// Bit-stream input and decoded (MSB, LSB) output handshakes of the Rice decoder.
interface rice_if
    import rice_pkg::*;
#(
    parameter int MSB_W = rice_pkg::MSB_W,
    parameter int LSB_W = rice_pkg::LSB_W
);
    logic             iBit;
    logic             iBitValid;
    logic             oBitReady;
    logic [MSB_W-1:0] oMSB;
    logic [LSB_W-1:0] oLSB;
    logic             oValid;
    logic             iReady;

    // slave = decoder side, master = bitstream source plus residual demapper
    modport slave (
        input  iBit, iBitValid, iReady,
        output oBitReady, oMSB, oLSB, oValid
    );

    modport master (
        output iBit, iBitValid, iReady,
        input  oBitReady, oMSB, oLSB, oValid
    );
endinterface

// File: rtl/rice_bit_shifter.sv
// Remainder shift register plus k-bit counter; oLastBit flags that the current bit is the k-th.
module rice_bit_shifter #(
    parameter int LSB_W   = rice_pkg::LSB_W,
    parameter int PARAM_W = rice_pkg::PARAM_W
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iClear,
    input  logic               iShift,
    input  logic               iBit,
    input  logic [PARAM_W-1:0] iK,
    output logic [LSB_W-1:0]   oLsb,
    output logic               oLastBit
);
    logic [PARAM_W-1:0] bitCnt;

    // Only meaningful while shifting, where k is known to be non-zero.
    assign oLastBit = (bitCnt == iK - PARAM_W'(1));

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
    // shift and the counter update stay in lockstep regardless of statement order.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oLsb   <= '0;
            bitCnt <= '0;
        end else if (iClear) begin
            oLsb   <= '0;
            bitCnt <= '0;
        end else if (iShift) begin
            oLsb   <= {oLsb[LSB_W-2:0], iBit};
            bitCnt <= bitCnt + PARAM_W'(1);
        end
    end
endmodule

// File: rtl/rice_decoder.sv
// Bit-serial Rice codeword decoder for one FLAC residual partition.
// Optional RICE_OVF_DET_EN: adds sticky oErr on unary quotient overflow and drops the partition.
module rice_decoder #(
    parameter int MSB_W   = rice_pkg::MSB_W,
    parameter int LSB_W   = rice_pkg::LSB_W,
    parameter int PARAM_W = rice_pkg::PARAM_W,
    parameter int CNT_W   = rice_pkg::CNT_W
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iPartStart,
    input  logic [PARAM_W-1:0] iRiceParam,
    input  logic [CNT_W-1:0]   iPartSamples,
    rice_if.slave              bus,
    output logic               oPartDone,
    output logic               oBusy
`ifdef RICE_OVF_DET_EN
    ,
    output logic               oErr
`endif
);
    import rice_pkg::*;

    state_t             state;
    logic [MSB_W-1:0]   msbCnt;
    logic [CNT_W-1:0]   remCnt;
    logic [PARAM_W-1:0] kReg;
    logic               bitReady;
    logic               valid;
    logic               bitAccept;
    logic               pairAccept;
    logic               shClear;
    logic               shShift;
    logic               shLast;
    logic [LSB_W-1:0]   lsbVal;

    assign bitAccept  = bus.iBitValid && bitReady;
    assign pairAccept = valid && bus.iReady;
    // Remainder restarts at zero for every codeword so k=0 yields LSB=0.
    assign shClear    = (state == IDLE && iPartStart) || pairAccept;
    assign shShift    = (state == BINARY) && bitAccept;

    rice_bit_shifter #(
        .LSB_W   (LSB_W),
        .PARAM_W (PARAM_W)
    ) uShifter (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iClear   (shClear),
        .iShift   (shShift),
        .iBit     (bus.iBit),
        .iK       (kReg),
        .oLsb     (lsbVal),
        .oLastBit (shLast)
    );

    assign bus.oBitReady = bitReady;
    assign bus.oValid    = valid;
    assign bus.oMSB      = msbCnt;
    assign bus.oLSB      = lsbVal;

    // Output flags are updated alongside each transition so they are true flop outputs.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= IDLE;
            msbCnt    <= '0;
            remCnt    <= '0;
            kReg      <= '0;
            bitReady  <= 1'b0;
            valid     <= 1'b0;
            oPartDone <= 1'b0;
            oBusy     <= 1'b0;
`ifdef RICE_OVF_DET_EN
            oErr      <= 1'b0;
`endif
        end else begin
            oPartDone <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (iPartStart) begin
                        kReg   <= iRiceParam;
                        remCnt <= iPartSamples;
                        msbCnt <= '0;
                        oBusy  <= 1'b1;
`ifdef RICE_OVF_DET_EN
                        oErr   <= 1'b0;
`endif
                        if (iPartSamples == '0) begin
                            state     <= DONE;
                            oPartDone <= 1'b1;
                        end else begin
                            state    <= UNARY;
                            bitReady <= 1'b1;
                        end
                    end
                end
                UNARY: begin
                    if (bitAccept) begin
                        if (!bus.iBit) begin
`ifdef RICE_OVF_DET_EN
                            if (&msbCnt) begin
                                oErr     <= 1'b1;
                                state    <= IDLE;
                                bitReady <= 1'b0;
                                oBusy    <= 1'b0;
                            end else begin
                                msbCnt <= msbCnt + MSB_W'(1);
                            end
`else
                            msbCnt <= msbCnt + MSB_W'(1);
`endif
                        end else if (kReg == '0) begin
                            state    <= OUT;
                            bitReady <= 1'b0;
                            valid    <= 1'b1;
                        end else begin
                            state <= BINARY;
                        end
                    end
                end
                BINARY: begin
                    if (bitAccept && shLast) begin
                        state    <= OUT;
                        bitReady <= 1'b0;
                        valid    <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.iReady) begin
                        valid  <= 1'b0;
                        msbCnt <= '0;
                        remCnt <= remCnt - CNT_W'(1);
                        if (remCnt == CNT_W'(1)) begin
                            state     <= DONE;
                            oPartDone <= 1'b1;
                        end else begin
                            state    <= UNARY;
                            bitReady <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    oBusy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bitReady <= 1'b0;
                    valid    <= 1'b0;
                    oBusy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rice_decoder.sv
// Self-checking bench: codewords are built from (quotient, remainder) pairs and the decoded stream is
// compared against them, with randomized bit-valid gaps and downstream back-pressure.
module tb_rice_decoder;
`ifdef RICE_OVF_DET_EN
    localparam int TB_MSB_W = 4;
`else
    localparam int TB_MSB_W = 16;
`endif

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iPartStart;
    logic [3:0]  iRiceParam;
    logic [15:0] iPartSamples;
    logic        oPartDone;
    logic        oBusy;
`ifdef RICE_OVF_DET_EN
    logic        oErr;
`endif

    int total = 0;
    int bad   = 0;
    int pairQ[$];
    int pairR[$];

    rice_if #(.MSB_W(TB_MSB_W), .LSB_W(16)) bus ();

    rice_decoder #(.MSB_W(TB_MSB_W), .LSB_W(16), .PARAM_W(4), .CNT_W(16)) dut (
        .iClk         (iClk),
        .iRst_n       (iRst_n),
        .iPartStart   (iPartStart),
        .iRiceParam   (iRiceParam),
        .iPartSamples (iPartSamples),
        .bus          (bus),
        .oPartDone    (oPartDone),
        .oBusy        (oBusy)
`ifdef RICE_OVF_DET_EN
        ,
        .oErr         (oErr)
`endif
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pair(input int q, input int r);
        pairQ.push_back(q);
        pairR.push_back(r);
    endtask

    // Decode one partition made of the queued pairs. Entered and left at a falling edge.
    task automatic run_partition(input int k, input int validPct, input int readyPct,
                                 input int holdFirst);
        bit  bits[$];
        bit  lastFlag[$];
        int  expQ[$];
        int  expR[$];
        int  n = pairQ.size();
        int  stall = holdFirst;
        int  cyc = 0;
        bit  wantValid = 1'b0;
        bit  holding = 1'b0;
        bit  doneNext;
        bit  finished = 1'b0;
        logic [31:0] heldM = '0;
        logic [31:0] heldL = '0;

        // Rice codeword: q zeros, a terminating one, then the k remainder bits MSB-first.
        for (int i = 0; i < n; i++) begin
            for (int z = 0; z < pairQ[i]; z++) begin
                bits.push_back(1'b0);
                lastFlag.push_back(1'b0);
            end
            bits.push_back(1'b1);
            lastFlag.push_back(k == 0);
            for (int b = k - 1; b >= 0; b--) begin
                bits.push_back(1'((pairR[i] >> b) & 1));
                lastFlag.push_back(b == 0);
            end
            expQ.push_back(pairQ[i] % (1 << TB_MSB_W));
            expR.push_back(pairR[i]);
        end
        pairQ.delete();
        pairR.delete();
        doneNext = (n == 0);

        iPartStart   = 1'b1;
        iRiceParam   = 4'(k);
        iPartSamples = 16'(n);
        @(negedge iClk);
        iPartStart   = 1'b0;

        while (!finished) begin
            if (cyc > 3000) begin
                check("partition timeout", 32'd0, 32'd1);
                break;
            end
            if (doneNext) begin
                check("part done pulse", oPartDone, 1);
                check("busy in done", oBusy, 1);
                finished = 1'b1;
            end else begin
                check("no early done", oPartDone, 0);
                check("busy", oBusy, 1);
            end
            if (wantValid) check("valid latency", bus.oValid, 1);
            if (holding) begin
                check("msb stable", bus.oMSB, heldM);
                check("lsb stable", bus.oLSB, heldL);
            end
            if (bus.oValid) check("bitready low in out", bus.oBitReady, 0);
            if (bits.size() == 0) check("no bitready without stream", bus.oBitReady, 0);

            bus.iReady    = (stall > 0 && bus.oValid) ? 1'b0 : ($urandom_range(99) < readyPct);
            if (bus.oValid && stall > 0) stall--;
            bus.iBitValid = (bits.size() > 0) && ($urandom_range(99) < validPct);
            bus.iBit      = (bits.size() > 0) ? bits[0] : 1'b0;

            wantValid = 1'b0;
            holding   = 1'b0;
            if (bus.oValid) begin
                if (expQ.size() == 0) begin
                    check("spurious valid", 32'd1, 32'd0);
                end else if (bus.iReady) begin
                    check("msb", bus.oMSB, expQ.pop_front());
                    check("lsb", bus.oLSB, expR.pop_front());
                    if (expQ.size() == 0) doneNext = 1'b1;
                end else begin
                    holding = 1'b1;
                    heldM   = bus.oMSB;
                    heldL   = bus.oLSB;
                end
            end
            if (bus.oBitReady && bus.iBitValid && bits.size() > 0) begin
                wantValid = lastFlag.pop_front();
                void'(bits.pop_front());
            end
            @(negedge iClk);
            cyc++;
        end
        bus.iBitValid = 1'b0;
        bus.iReady    = 1'b0;
        check("done is one pulse", oPartDone, 0);
        check("idle after done", oBusy, 0);
    endtask

    initial begin
        iRst_n        = 1'b0;
        iPartStart    = 1'b0;
        iRiceParam    = '0;
        iPartSamples  = '0;
        bus.iBit      = 1'b0;
        bus.iBitValid = 1'b0;
        bus.iReady    = 1'b0;
        repeat (3) @(negedge iClk);
        check("reset valid", bus.oValid, 0);
        check("reset bitready", bus.oBitReady, 0);
        check("reset msb", bus.oMSB, 0);
        check("reset lsb", bus.oLSB, 0);
        check("reset done", oPartDone, 0);
        check("reset busy", oBusy, 0);
        iRst_n = 1'b1;
        @(negedge iClk);

        // k=2, bits 000 1 10
        add_pair(3, 2);
        run_partition(2, 100, 100, 0);

        // k=0, bits 1 / 01 / 001
        add_pair(0, 0);
        add_pair(1, 0);
        add_pair(2, 0);
        run_partition(0, 100, 100, 0);

        // k=4, first pair held by downstream for 5 cycles
        add_pair(2, 9);
        add_pair(0, 13);
        run_partition(4, 100, 100, 5);

        // Empty partition
        run_partition(5, 100, 100, 0);

        // Reset in the middle of a k=3 remainder
        iPartStart   = 1'b1;
        iRiceParam   = 4'd3;
        iPartSamples = 16'd2;
        @(negedge iClk);
        iPartStart    = 1'b0;
        bus.iBit      = 1'b1;
        bus.iBitValid = 1'b1;
        @(negedge iClk);
        iPartStart   = 1'b1;
        iPartSamples = 16'd0;
        @(negedge iClk);
        iPartStart    = 1'b0;
        bus.iBitValid = 1'b0;
        check("start ignored done", oPartDone, 0);
        check("start ignored busy", oBusy, 1);
        check("still in remainder", bus.oBitReady, 1);
        check("partial remainder", bus.oLSB, 1);
        #2 iRst_n = 1'b0;
        #1;
        check("async reset valid", bus.oValid, 0);
        check("async reset bitready", bus.oBitReady, 0);
        check("async reset msb", bus.oMSB, 0);
        check("async reset lsb", bus.oLSB, 0);
        check("async reset done", oPartDone, 0);
        check("async reset busy", oBusy, 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        @(negedge iClk);
        add_pair(1, 5);
        add_pair(4, 6);
        run_partition(3, 100, 100, 0);

        // Randomized partitions with gaps and back-pressure
        for (int p = 0; p < 8; p++) begin
            int k = $urandom_range(15);
            int n = $urandom_range(6, 1);
            for (int i = 0; i < n; i++)
                add_pair($urandom_range(8), int'($urandom & ((32'd1 << k) - 1)));
            run_partition(k, $urandom_range(100, 40), $urandom_range(100, 40), $urandom_range(3));
        end

`ifdef RICE_OVF_DET_EN
        // Quotient overflow with a 4-bit counter: the 16th zero overflows
        iPartStart   = 1'b1;
        iRiceParam   = 4'd0;
        iPartSamples = 16'd1;
        @(negedge iClk);
        iPartStart    = 1'b0;
        bus.iBit      = 1'b0;
        bus.iBitValid = 1'b1;
        repeat (16) @(negedge iClk);
        bus.iBitValid = 1'b0;
        check("ovf err", oErr, 1);
        check("ovf idle", oBusy, 0);
        check("ovf no valid", bus.oValid, 0);
        check("ovf no bitready", bus.oBitReady, 0);
        @(negedge iClk);
        check("ovf err sticky", oErr, 1);
        check("ovf no done", oPartDone, 0);
        add_pair(2, 0);
        run_partition(0, 100, 100, 0);
        check("err cleared by start", oErr, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
